// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler
//   SPI mode-0 master that time-shares one SPI bus between NUM_REQ clients.
//   It arbitrates pending requests and drops the winner's chip select. Then it
//   runs one DATA_W-bit full-duplex transfer, MSB first, and returns the word
//   received on MISO.
//
//   Optional build macro:
//     SPI_FIXED_PRIO_EN  Fixed priority, where the lowest requester index wins.
//                        When this macro is undefined, the block uses
//                        round-robin arbitration.
//
//   Ports
//     clk       system clock; all logic on rising edge
//     reset     asynchronous, active-high; clears all state
//     req       per-client request level, held until granted
//     req_data  per-client TX word; slice i = req_data[i*DATA_W +: DATA_W]
//     grant     one-hot; high for the whole transfer of the winner
//     done      1-cycle pulse; rx_data valid in the same cycle
//     rx_data   last received word, held until the next done
//     busy      high from grant through the done cycle
//     SCLK      SPI clock, idles low
//     CS        active-low chip selects, at most one low
//     MOSI      serial out, MSB first
//     MISO      serial in, MSB first
//
//   Timeline relative to the edge that raises grant (C = CLK_DIV, D = DATA_W):
//     SETUP  C cycles     : CS low, MOSI = MSB, SCLK low
//     SHIFT  2*D*C cycles : SCLK high/low half-periods, D rising edges
//     HOLD   C cycles     : SCLK low, CS still low
//     DONE   1 cycle      : CS already high; done is registered here
//   The done pulse is therefore visible (2*D+2)*C+1 cycles after grant rises.
//   CS is high during the DONE state and during the following IDLE cycle.

module spi_bus_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      SCLK,
  output logic [NUM_REQ-1:0]        CS,
  output logic                      MOSI,
  input  logic                      MISO
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } stateT;

  stateT             state;
  stateT             stateNext;

  logic [DIV_W-1:0]  divCnt;
  logic [HALF_W-1:0] halfCnt;
  logic              divEnd;

  logic [DATA_W-1:0] txShift;
  logic [DATA_W-1:0] txNext;
  logic [DATA_W-1:0] rxShift;
  logic [DATA_W-1:0] txLoad;

  logic              anyReq;
  logic [PTR_W-1:0]  winIdx;
  logic [PTR_W-1:0]  candIdx;
  logic [NUM_REQ-1:0] grantOh;

  // FSM strobes
  logic              doGrant;
  logic              sclkRise;
  logic              sclkFall;
  logic              csRelease;
  logic              finish;

`ifndef SPI_FIXED_PRIO_EN
  // Index at which the next search starts (one past the last winner).
  logic [PTR_W-1:0]  rrPtr;
  logic [PTR_W-1:0]  rrPtrNext;
`endif

  assign divEnd = (divCnt == DIV_LAST);
  assign txNext = txShift << 1;

  // Arbiter: scan all requesters starting from the search origin and take
  // the first one that is asserted.
  always_comb begin
    anyReq  = 1'b0;
    winIdx  = '0;
    candIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SPI_FIXED_PRIO_EN
      candIdx = PTR_W'(k);
`else
      candIdx = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
`endif
      if (!anyReq && req[candIdx]) begin
        anyReq = 1'b1;
        winIdx = candIdx;
      end
    end
  end

  assign grantOh = NUM_REQ'(1) << winIdx;
  assign txLoad  = req_data[int'(winIdx) * DATA_W +: DATA_W];

`ifndef SPI_FIXED_PRIO_EN
  assign rrPtrNext = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (doGrant) begin
      rrPtr <= rrPtrNext;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and per-cycle strobes
  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    sclkRise  = 1'b0;
    sclkFall  = 1'b0;
    csRelease = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          doGrant   = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        // The first rising SCLK edge opens SHIFT.
        if (divEnd) begin
          sclkRise  = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        // halfCnt counts toggles made inside SHIFT. After 2*D-1 toggles,
        // SCLK is low past the last falling edge, so the last low half ends.
        if (divEnd) begin
          if (halfCnt == HALF_LAST) begin
            stateNext = HOLD;
          end else if (SCLK) begin
            sclkFall = 1'b1;
          end else begin
            sclkRise = 1'b1;
          end
        end
      end
      HOLD: begin
        if (divEnd) begin
          csRelease = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Clock divider and half-period counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt  <= '0;
      halfCnt <= '0;
    end else begin
      if (state == SETUP || state == SHIFT || state == HOLD) begin
        divCnt <= divEnd ? '0 : divCnt + 1'b1;
      end else begin
        divCnt <= '0;
      end
      if (state != SHIFT) begin
        halfCnt <= '0;
      end else if (sclkRise || sclkFall) begin
        halfCnt <= halfCnt + 1'b1;
      end
    end
  end

  // SPI lines, shifters and client-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      CS      <= '1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      txShift <= '0;
      rxShift <= '0;
    end else begin
      done <= finish;

      if (doGrant) begin
        grant   <= grantOh;
        CS      <= ~grantOh;
        busy    <= 1'b1;
        txShift <= txLoad;
        MOSI    <= txLoad[DATA_W-1];
        rxShift <= '0;
      end else if (state == IDLE) begin
        // This clears busy in the cycle after the done pulse.
        busy <= 1'b0;
      end

      // MISO is captured on the same clk edge that raises SCLK.
      if (sclkRise) begin
        SCLK    <= 1'b1;
        rxShift <= DATA_W'({rxShift, MISO});
      end

      if (sclkFall) begin
        SCLK    <= 1'b0;
        txShift <= txNext;
        MOSI    <= txNext[DATA_W-1];
      end

      if (csRelease) begin
        CS   <= '1;
        MOSI <= 1'b0;
      end

      if (finish) begin
        grant   <= '0;
        rx_data <= rxShift;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_scheduler.sv
`timescale 1ns/1ps
module tb_spi_bus_scheduler;

  localparam int NR  = 2;
  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int LAT = (2 * DW + 2) * CD + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    grant;
  logic             done;
  logic [DW-1:0]    rx_data;
  logic             busy;
  logic             SCLK;
  logic [NR-1:0]    CS;
  logic             MOSI;
  logic             MISO = 1'b0;

  spi_bus_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .rx_data  (rx_data),
    .busy     (busy),
    .SCLK     (SCLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } expT;

  expT sbQ[$];
  expT monExp;

  int tests  = 0;
  int failed = 0;

  // Monitor / slave-model state
  int            cyc = 0;
  int            grantCycle = 0;
  int            grantCount = 0;
  int            csHighRun = 0;
  int            csViol = 0;
  logic [NR-1:0] grantSeen = '0;
  logic [NR-1:0] monPrevGrant = '0;
  logic [NR-1:0] monPrevCs = '1;
  logic [DW-1:0] slaveWord [NR];
  logic [DW-1:0] slvShift = '0;
  logic [DW-1:0] slvMosi = '0;
  int            slvRises = 0;
  int            slvSel = 0;
  logic          slvPrevSclk = 1'b0;
  logic [NR-1:0] slvPrevCs = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model plus scoreboard monitor, all sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc++;

    // SPI slave: load on CS fall, capture MOSI on SCLK rise, shift on fall
    if (CS != '1 && slvPrevCs == '1) begin
      slvSel   = CS[0] ? 1 : 0;
      slvShift = slaveWord[slvSel];
      MISO     = slvShift[DW-1];
      slvMosi  = '0;
      slvRises = 0;
    end else if (CS != '1) begin
      if (SCLK && !slvPrevSclk) begin
        slvMosi = {slvMosi[DW-2:0], MOSI};
        slvRises++;
      end
      if (!SCLK && slvPrevSclk) begin
        slvShift = slvShift << 1;
        MISO     = slvShift[DW-1];
      end
    end else begin
      MISO = 1'b0;
    end
    slvPrevSclk = SCLK;
    slvPrevCs   = CS;

    // Chip-select sanity: at most one low, only the granted line low
    if (((~CS) & (~grant)) != '0 || $countones(~CS) > 1) csViol++;

    // CS fully high for at least two cycles before each new transfer
    if (CS != '1 && monPrevCs == '1) begin
      check("cs_gap_ge2", (csHighRun >= 2) ? 32'd1 : 32'd0, 32'd1);
    end
    if (CS == '1) csHighRun++;
    else csHighRun = 0;
    monPrevCs = CS;

    if (grant != '0 && monPrevGrant == '0) begin
      grantCycle = cyc;
      grantSeen  = grant;
      grantCount++;
    end
    monPrevGrant = grant;

    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: done pulsed with rx_data 0x%0h, no transfer expected", rx_data);
      end else begin
        monExp = sbQ.pop_front();
        check("rx_data", rx_data, monExp.rx);
        check("grant_winner", grantSeen, monExp.gnt);
        check("done_latency", cyc - grantCycle, LAT);
        check("mosi_word", slvMosi, monExp.tx);
        check("sclk_rises", slvRises, DW);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic waitGrantCount(input int target, input string name);
    int n = 0;
    while (grantCount < target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_grant_seen"}, (grantCount >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((sbQ.size() != 0 || busy !== 1'b0) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_completed"}, sbQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g2;
    int base;
    int idleViol;

    slaveWord[0] = '0;
    slaveWord[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sclk", SCLK, 0);
    check("rst_cs", CS, 2'b11);
    check("rst_mosi", MOSI, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single req[0], TX 53, slave returns 09
    slaveWord[0] = 8'h09;
    req_data = {8'h00, 8'h53};
    req = 2'b01;
    sbQ.push_back('{2'b01, 8'h53, 8'h09});
    waitGrantCount(grantCount + 1, "t1");
    req = 2'b00;
    waitIdle("t1");

    // 2: single req[1], TX 3C, slave returns 98
    @(negedge clk);
    slaveWord[1] = 8'h98;
    req_data = {8'h3C, 8'h00};
    req = 2'b10;
    sbQ.push_back('{2'b10, 8'h3C, 8'h98});
    waitGrantCount(grantCount + 1, "t2");
    req = 2'b00;
    waitIdle("t2");

    // 3: both requesting continuously for three transfers
`ifdef SPI_FIXED_PRIO_EN
    g2 = 2'b01;
`else
    g2 = 2'b10;
`endif
    @(negedge clk);
    slaveWord[0] = 8'h0F;
    slaveWord[1] = 8'hF0;
    req_data = {8'h55, 8'hAA};
    sbQ.push_back('{2'b01, 8'hAA, 8'h0F});
    sbQ.push_back('{g2, (g2 == 2'b01) ? 8'hAA : 8'h55, (g2 == 2'b01) ? 8'h0F : 8'hF0});
    sbQ.push_back('{2'b01, 8'hAA, 8'h0F});
    base = grantCount;
    req = 2'b11;
    waitGrantCount(base + 3, "t3");
    req = 2'b00;
    waitIdle("t3");

    // 4: reset pulsed 10 cycles into a transfer
    @(negedge clk);
    slaveWord[0] = 8'h09;
    req_data = {8'h00, 8'h53};
    req = 2'b01;
    waitGrantCount(grantCount + 1, "t4");
    req = 2'b00;
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t4_cs", CS, 2'b11);
    check("t4_sclk", SCLK, 0);
    check("t4_mosi", MOSI, 0);
    check("t4_grant", grant, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_rx_data", rx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    req = 2'b01;
    sbQ.push_back('{2'b01, 8'h53, 8'h09});
    waitGrantCount(grantCount + 1, "t4b");
    req = 2'b00;
    waitIdle("t4b");

    // 5: req dropped and data changed mid-transfer
    @(negedge clk);
    req_data = {8'h00, 8'h53};
    req = 2'b01;
    sbQ.push_back('{2'b01, 8'h53, 8'h09});
    waitGrantCount(grantCount + 1, "t5");
    repeat (5) @(negedge clk);
    req = 2'b00;
    req_data = {8'hFF, 8'hFF};
    waitIdle("t5");

    // 6: idle for 100 cycles
    base = grantCount;
    idleViol = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (SCLK !== 1'b0 || CS !== 2'b11 || busy !== 1'b0 || done !== 1'b0) idleViol++;
    end
    check("t6_idle_violations", idleViol, 0);
    check("t6_rx_held", rx_data, 8'h09);
    check("t6_no_grant", grantCount - base, 0);

    check("cs_select_violations", csViol, 0);
    check("scoreboard_empty", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
